// File: rtl/output_router.sv
// rtl/output_router.sv - output-port round-robin flit router with per-VC wormhole locking
// One registered output stage; a head locks its VC to the winning input until the tail passes.
module output_router #(
  parameter int N_IN   = 5,
  parameter int FLIT_W = 37,
  parameter int N_VC   = 3,
  parameter int VC_W   = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_IN-1:0]          in_valid_i,
  input  logic [N_IN*FLIT_W-1:0]   in_flit_i,
  input  logic [N_IN*VC_W-1:0]     in_vc_i,
  output logic [N_IN-1:0]          in_ready_o,
  output logic                     out_valid_o,
  output logic [FLIT_W-1:0]        out_flit_o,
  output logic [VC_W-1:0]          out_vc_o,
  input  logic [N_VC-1:0]          out_ready_i
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic              r_out_valid;
  logic [FLIT_W-1:0] r_out_flit;
  logic [VC_W-1:0]   r_out_vc;
  logic [N_VC-1:0]   r_lock;
  logic [PTR_W-1:0]  r_owner [N_VC];
  logic [PTR_W-1:0]  r_ptr;

  logic              w_cur_ready;
  logic              w_slot_free;
  logic [N_IN-1:0]   w_elig;
  logic [N_IN-1:0]   w_grant;
  logic              w_any_grant;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [FLIT_W-1:0] w_gnt_flit;
  logic [VC_W-1:0]   w_gnt_vc;
  logic [1:0]        w_gnt_type;

  always_comb begin
    w_cur_ready = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (r_out_vc == VC_W'(v)) w_cur_ready = out_ready_i[v];
    end
    w_slot_free = !r_out_valid || w_cur_ready;
  end

  // Heads need a free VC; body/tail need the lock to be held by this very input.
  always_comb begin
    logic [FLIT_W-1:0] w_flit;
    logic [VC_W-1:0]   w_vc;
    logic [1:0]        w_type;
    logic              w_held;
    logic              w_mine;
    w_elig = '0;
    w_flit = '0;
    w_vc   = '0;
    w_type = '0;
    w_held = 1'b0;
    w_mine = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      w_flit = in_flit_i[i*FLIT_W +: FLIT_W];
      w_vc   = in_vc_i[i*VC_W +: VC_W];
      w_type = w_flit[FLIT_W-1 -: 2];
      w_held = 1'b0;
      w_mine = 1'b0;
      for (int v = 0; v < N_VC; v++) begin
        if (w_vc == VC_W'(v)) begin
          w_held = r_lock[v];
          w_mine = (r_owner[v] == PTR_W'(i));
        end
      end
      w_elig[i] = in_valid_i[i] && w_slot_free && (32'(w_vc) < 32'(N_VC)) &&
                  ((!w_held && (w_type == T_HEAD || w_type == T_HT)) ||
                   (w_held && w_mine && (w_type == T_BODY || w_type == T_TAIL)));
    end
  end

  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_grant     = '0;
    w_any_grant = 1'b0;
    w_gnt_idx   = '0;
    w_idx       = '0;
    for (int k = 1; k <= N_IN; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N_IN);
      if (!w_any_grant && w_elig[w_idx]) begin
        w_any_grant    = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gnt_idx      = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt_flit = '0;
    w_gnt_vc   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant[i]) begin
        w_gnt_flit = in_flit_i[i*FLIT_W +: FLIT_W];
        w_gnt_vc   = in_vc_i[i*VC_W +: VC_W];
      end
    end
    w_gnt_type = w_gnt_flit[FLIT_W-1 -: 2];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_out_vc    <= '0;
      r_lock      <= '0;
      r_ptr       <= PTR_W'(N_IN - 1);
      for (int v = 0; v < N_VC; v++) r_owner[v] <= '0;
    end else if (w_any_grant) begin
      r_out_valid <= 1'b1;
      r_out_flit  <= w_gnt_flit;
      r_out_vc    <= w_gnt_vc;
      r_ptr       <= w_gnt_idx;
      for (int v = 0; v < N_VC; v++) begin
        if (w_gnt_vc == VC_W'(v)) begin
          if (w_gnt_type == T_HEAD) begin
            r_lock[v]  <= 1'b1;
            r_owner[v] <= w_gnt_idx;
          end else if (w_gnt_type == T_TAIL) begin
            r_lock[v]  <= 1'b0;
          end
        end
      end
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready_o  = w_grant;
  assign out_valid_o = r_out_valid;
  assign out_flit_o  = r_out_flit;
  assign out_vc_o    = r_out_vc;

endmodule
